// File: rtl/traffic_light_pkg.sv
// Shared definitions for the traffic light controller and its phase timer.
package traffic_light_pkg;

  // Phase encodings shared with the FSM; the config select reuses them.
  typedef enum logic [1:0] {
    PH_IDLE   = 2'b00,
    PH_RED    = 2'b01,
    PH_GREEN  = 2'b10,
    PH_YELLOW = 2'b11
  } phase_e;

  localparam int CNT_W_DEF     = 8;
  localparam int PRESC_W_DEF   = 16;
  localparam int PRESC_DIV_DEF = 50000;
  localparam int RED_DEF_T     = 30;
  localparam int YELLOW_DEF_T  = 5;
  localparam int GREEN_DEF_T   = 25;

endpackage

// File: rtl/traffic_light_timer_if.sv
// Duration configuration port: valid/ready write of one phase duration.
interface traffic_light_timer_if
  import traffic_light_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);
  logic             cfg_valid;
  logic [1:0]       cfg_sel;
  logic [CNT_W-1:0] cfg_data;
  logic             cfg_ready;

  modport master (output cfg_valid, cfg_sel, cfg_data, input cfg_ready);
  modport slave  (input cfg_valid, cfg_sel, cfg_data, output cfg_ready);
endinterface

// File: rtl/traffic_light_timer_tick_prescaler.sv
// Divides clk down to a one-cycle tick every PRESC_DIV cycles; clear restarts the period.
module tick_prescaler
  import traffic_light_pkg::*;
#(
  parameter int PRESC_W   = PRESC_W_DEF,
  parameter int PRESC_DIV = PRESC_DIV_DEF
) (
  input  logic clk,
  input  logic reset_b,
  input  logic clear,
  output logic tick
);

  localparam logic [PRESC_W-1:0] DIV_M1 = PRESC_W'(PRESC_DIV - 1);

  logic [PRESC_W-1:0] presc_r;

  // Prescale counter: clear wins over the natural wrap.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      presc_r <= '0;
    end else if (clear) begin
      presc_r <= '0;
    end else if (presc_r == DIV_M1) begin
      presc_r <= '0;
    end else begin
      presc_r <= presc_r + PRESC_W'(1);
    end
  end

  assign tick = (presc_r == DIV_M1);

endmodule

// File: rtl/traffic_light_timer.sv
// Phase timer: counts ticks in the current light phase and flags when the programmed duration is reached.
module traffic_light_timer
  import traffic_light_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int PRESC_W    = PRESC_W_DEF,
  parameter int PRESC_DIV  = PRESC_DIV_DEF,
  parameter int RED_DEF    = RED_DEF_T,
  parameter int YELLOW_DEF = YELLOW_DEF_T,
  parameter int GREEN_DEF  = GREEN_DEF_T
) (
  input  logic                  clk,
  input  logic                  reset_b,
  input  logic                  clear,
  input  logic                  red,
  input  logic                  yellow,
  input  logic                  green,
  traffic_light_timer_if.slave  cfg,
  output logic                  eq_red_time,
  output logic                  eq_yellow_time,
  output logic                  eq_green_time,
  output logic [CNT_W-1:0]      count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // A zero duration would never let the phase run at all, so it is promoted to one tick.
  function automatic logic [CNT_W-1:0] nonzero_dur(input logic [CNT_W-1:0] d);
    return (d == '0) ? CNT_W'(1) : d;
  endfunction

  logic             tick_s;
  logic             accept_s;
  logic             apply_s;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] dur_red_r;
  logic [CNT_W-1:0] dur_yellow_r;
  logic [CNT_W-1:0] dur_green_r;
  logic             pend_valid_r;
  phase_e           pend_sel_r;
  logic [CNT_W-1:0] pend_data_r;

  tick_prescaler #(
    .PRESC_W   (PRESC_W),
    .PRESC_DIV (PRESC_DIV)
  ) u_presc (
    .clk     (clk),
    .reset_b (reset_b),
    .clear   (clear),
    .tick    (tick_s)
  );

  assign accept_s = cfg.cfg_valid & ~pend_valid_r;
  assign apply_s  = clear & pend_valid_r;

  // Phase counter, saturating so an overshooting phase keeps its flag.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (tick_s && (count_r != CNT_MAX)) begin
      count_r <= count_r + CNT_W'(1);
    end
  end

  // Single-entry pending buffer; reserved selects are consumed without being stored.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      pend_valid_r <= 1'b0;
      pend_sel_r   <= PH_IDLE;
      pend_data_r  <= '0;
    end else if (apply_s) begin
      pend_valid_r <= 1'b0;
    end else if (accept_s && (cfg.cfg_sel != 2'b00)) begin
      pend_valid_r <= 1'b1;
      pend_sel_r   <= phase_e'(cfg.cfg_sel);
      pend_data_r  <= cfg.cfg_data;
    end
  end

  // Active durations change only at a phase boundary so a running phase keeps its length.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      dur_red_r    <= CNT_W'(RED_DEF);
      dur_yellow_r <= CNT_W'(YELLOW_DEF);
      dur_green_r  <= CNT_W'(GREEN_DEF);
    end else if (apply_s) begin
      case (pend_sel_r)
        PH_RED:    dur_red_r    <= nonzero_dur(pend_data_r);
        PH_GREEN:  dur_green_r  <= nonzero_dur(pend_data_r);
        PH_YELLOW: dur_yellow_r <= nonzero_dur(pend_data_r);
        default:   dur_red_r    <= dur_red_r;
      endcase
    end
  end

  assign cfg.cfg_ready   = ~pend_valid_r;
  assign count           = count_r;
  assign eq_red_time     = red    & (count_r >= dur_red_r);
  assign eq_yellow_time  = yellow & (count_r >= dur_yellow_r);
  assign eq_green_time   = green  & (count_r >= dur_green_r);

endmodule

// File: doc/traffic_light_timer.md
# traffic_light_timer

Phase timer and duration-configuration datapath paired with the traffic light controller FSM. Counts elapsed seconds in the current light phase using a prescaled tick, compares against per-phase programmable durations, and drives the FSM's `eq_red_time` / `eq_yellow_time` / `eq_green_time` inputs. It consumes the FSM's `clear`, `red`, `yellow` and `green` outputs. Duration updates arrive over a valid/ready config port and take effect only at phase boundaries.

## Interface
- `CNT_W`, 8: width of phase counter and duration registers.
- `PRESC_W`, 16: prescaler width.
- `PRESC_DIV`, 50000: clk cycles per tick; legal range 1..2^PRESC_W-1.
- `RED_DEF`, 30: reset red duration, in ticks.
- `YELLOW_DEF`, 5: reset yellow duration, in ticks.
- `GREEN_DEF`, 25: reset green duration, in ticks.

Ports:
- `clk` in 1: clock.
- `reset_b` in 1: asynchronous, active-low reset.
- `clear` in 1: from FSM; zeroes the phase counter and prescaler and applies any pending config.
- `red`, `yellow`, `green` in 1 each: FSM light outputs; select which duration is compared.
- `cfg_valid` in 1: config write request.
- `cfg_sel` in 2: 01 = red, 10 = green, 11 = yellow, 00 = reserved.
- `cfg_data` in CNT_W: new duration, in ticks.
- `cfg_ready` out 1: config write accepted when high together with `cfg_valid`.
- `eq_red_time`, `eq_yellow_time`, `eq_green_time` out 1 each: phase-expired flags.
- `count` out CNT_W: current phase count, for debug.

## Operation
- **Prescaler:** `presc` counts 0..PRESC_DIV-1 and wraps. `tick` = (`presc` == PRESC_DIV-1). `clear` forces `presc` to 0, and `clear` has priority over the wrap.
- **Phase counter:**
  - `clear` → `count` = 0.
  - Otherwise, `tick` → `count` + 1, saturating at 2^CNT_W-1.
  - `count` is held at 0 throughout IDLE, because the FSM asserts `clear` there.
- **Compare (combinational from registers):**
  - `eq_red_time` = `red` & (`count` >= `dur_red`); same pattern for yellow and green.
  - The `>=` comparison keeps the flag asserted if a phase overshoots.
  - Each flag is gated only by its own light input. No one-hot checking.
- **Active durations:** `dur_red`, `dur_yellow`, `dur_green` reset to their defaults. A written value of 0 is stored as 1.
- **Config handshake:**
  - Single-entry pending buffer; `cfg_ready` = ~`pend_valid`.
  - Accept (`cfg_valid` & `cfg_ready`) with `cfg_sel` != 00: latch `pend_sel` and `pend_data`, set `pend_valid`.
  - Accept with `cfg_sel` == 00: consumed and discarded; `pend_valid` stays 0.
  - Apply: on a cycle with `clear` & `pend_valid`, copy `pend_data` into the selected active register and clear `pend_valid`. `cfg_ready` returns high the following cycle.
  - Accept and `clear` in the same cycle (`pend_valid` was 0): the value goes to pending only and is applied at the next `clear`.
  - `cfg_valid` without `cfg_ready`: no effect. The master holds `cfg_sel`/`cfg_data` stable until accepted.
- **Reset (async, reset_b low):**
  - `presc` = 0, `count` = 0, `pend_valid` = 0.
  - Durations = their `*_DEF` values.
  - `cfg_ready` = 1.
  - Eq flags = 0 while the FSM outputs are 0.
  - Reset mid-phase discards any pending write and restores default durations.

## Timing
- Registered state updates on `clk` rising edge. Eq flags are combinational, with zero-cycle latency from `count` and the light inputs.
- With `clear` at edge E0 and duration D: `count` reaches D at edge E0 + D·PRESC_DIV. The eq flag is high in the following cycle, and the FSM leaves the phase (asserting `clear`) at edge E0 + D·PRESC_DIV + 1.
- Phase length is therefore D·PRESC_DIV + 1 cycles.
- A config write takes effect on the first `clear` edge strictly after acceptance. It never changes the duration of the phase in progress.
- PRESC_DIV = 1: `tick` is high every non-clear cycle.

## Structure
- Package `traffic_light_pkg`:
  - Phase encodings IDLE/RED/GREEN/YELLOW = 00/01/10/11, shared with the FSM; `cfg_sel` reuses them.
  - Default durations.
  - CNT_W and PRESC_W defaults.
- Sub-module `tick_prescaler`: ports `clk`, `reset_b`, `clear` → `tick`; parameters PRESC_W and PRESC_DIV.
- Top holds the phase counter, duration registers, pending buffer and comparators.

## Test plan
All scenarios use PRESC_DIV = 4 and defaults R/Y/G = 3/2/2.

1. **Reset:** `reset_b` low mid-count with `pend_valid` = 1 → `count` = 0, `cfg_ready` = 1, durations 3/2/2.
2. **Single red phase:** `red` = 1 with `clear` pulsed at E0 → `eq_red_time` rises after edge E0+12 and stays high until the `clear` edge at E0+13.
3. **Deferred config:** write `cfg_sel` = 01, `cfg_data` = 5 mid-red-phase → `cfg_ready` low, current phase still ends at `count` = 3; the next red phase ends at `count` = 5.
4. **Accept coincident with clear:** write `cfg_sel` = 11, `cfg_data` = 0 in the same cycle as `clear` → not applied at that clear; applied as 1 at the next clear; `cfg_ready` high the cycle after.
5. **Reserved select and held request:** `cfg_sel` = 00 write → accepted, no duration changes. A second write while `pend_valid` = 1 → `cfg_ready` = 0; it completes the cycle after the apply.
6. **Saturation:** CNT_W = 3, `green` = 1, no `clear` for 40 ticks → `count` holds at 7 and `eq_green_time` stays 1.
